pipeline_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage core: fetch, decode, execute, memory, writeback.
- Drives the fetch-register stall and flush, the decode-stage flush (bubble into execute), the global freeze during data-memory wait, and the execute-operand forwarding selects.
- Sits beside the pipeline registers; it is pure control and holds no datapath.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 31 +++
 rtl/pipeline_hazard_ctrl_forward_sel.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared core definitions for the hazard controller: result_src encodings,
// forwarding selects, hazard FSM states and the register-match helper.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ALU_RESULT = 2'b00,
    MEM_TO_REG = 2'b01,
    PC_PLUS    = 2'b10,
    LUI_AUIPC  = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    REDIRECT = 2'b01,
    MEM_WAIT = 2'b10
  } hz_state_e;

  // x0 is hardwired to zero, so it never matches as a producer
  function automatic logic reg_hit(input logic       we,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// Execute-operand forwarding select for one source register; memory stage
// result wins over writeback.
module forward_sel
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_hit(mem_regwrite, mem_rd, rs)) begin
      sel = FWD_MEM;
    end else if (reg_hit(wb_regwrite, wb_rd, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core (stall, flush, freeze,
// forwarding). Optional perf counters enabled by `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        stall_fetch,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic        freeze,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_events,
  output logic [31:0] perf_wait_cycles
`endif
);

  localparam int unsigned WAIT_MAX = (MEM_TIMEOUT == 0) ? 1 : MEM_TIMEOUT;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 2);
  localparam int unsigned FLUSH_W  = 3;

  hz_state_e           state_q, state_d;
  logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0]   wait_now;
  logic                load_use;
  logic [1:0]          fwd_a_raw, fwd_b_raw;

  forward_sel u_fwd_a (
    .rs           (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (fwd_a_raw)
  );

  forward_sel u_fwd_b (
    .rs           (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (fwd_b_raw)
  );

  assign fwd_a = rst ? 2'b00 : fwd_a_raw;
  assign fwd_b = rst ? 2'b00 : fwd_b_raw;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    stall_fetch  = 1'b0;
    flush_fetch  = 1'b0;
    flush_decode = 1'b0;
    freeze       = 1'b0;
    mem_timeout  = 1'b0;
    wait_now     = wait_cnt_q + WAIT_W'(1);
    load_use     = ex_is_load && reg_hit(ex_regwrite, ex_rd, id_rs1) ||
                   ex_is_load && reg_hit(ex_regwrite, ex_rd, id_rs2);

    unique case (state_q)
      RUN: begin
        // The RUN cycle that sees the miss is already wait cycle 1
        if (dmem_req && !dmem_ready) begin
          freeze      = 1'b1;
          mem_timeout = (MEM_TIMEOUT == 1);
          wait_cnt_d  = WAIT_W'(1);
          state_d     = MEM_WAIT;
        end else if (ex_redirect) begin
          flush_fetch  = 1'b1;
          flush_decode = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_d = FLUSH_W'(1);
            state_d     = REDIRECT;
          end
        end else if (load_use) begin
          stall_fetch  = 1'b1;
          flush_decode = 1'b1;
        end
      end
      REDIRECT: begin
        flush_fetch = 1'b1;
        if (ex_redirect) begin
          flush_cnt_d = FLUSH_W'(1);
        end else if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
          flush_cnt_d = '0;
          state_d     = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          wait_cnt_d = '0;
          state_d    = RUN;
        end else begin
          freeze      = 1'b1;
          stall_fetch = 1'b1;
          mem_timeout = (MEM_TIMEOUT != 0) && (wait_now == WAIT_W'(MEM_TIMEOUT));
          if (wait_cnt_q != WAIT_W'(WAIT_MAX)) begin
            wait_cnt_d = wait_now;
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      stall_fetch  = 1'b0;
      flush_fetch  = 1'b1;
      flush_decode = 1'b1;
      freeze       = 1'b0;
      mem_timeout  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_wait_q,  perf_wait_d;
  logic        load_use_cycle, redirect_event;

  // A redirect is counted when accepted in RUN or when it restarts REDIRECT
  always_comb begin
    load_use_cycle = stall_fetch && flush_decode;
    redirect_event = (state_q == RUN) && flush_fetch && flush_decode && !rst ||
                     (state_q == REDIRECT) && ex_redirect;
    perf_stall_d   = perf_stall_q + {31'd0, load_use_cycle};
    perf_flush_d   = perf_flush_q + {31'd0, redirect_event};
    perf_wait_d    = perf_wait_q  + {31'd0, state_q == MEM_WAIT};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_events = perf_flush_q;
  assign perf_wait_cycles  = perf_wait_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=3):
// vector table, directed multi-cycle sequences and a randomized reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned FC = 2;
  localparam int unsigned MT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_regwrite, ex_is_load, ex_redirect, mem_regwrite, wb_regwrite;
  logic       dmem_req, dmem_ready;
  logic       stall_fetch, flush_fetch, flush_decode, freeze, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_events, perf_wait_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_is_load   (ex_is_load),
    .ex_redirect  (ex_redirect),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .stall_fetch  (stall_fetch),
    .flush_fetch  (flush_fetch),
    .flush_decode (flush_decode),
    .freeze       (freeze),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mem_timeout  (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_events (perf_flush_events),
    .perf_wait_cycles  (perf_wait_cycles)
`endif
  );

  typedef struct {
    string      name;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic       ex_regwrite, ex_is_load;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
    logic       exp_stall, exp_fd;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t tbl[12];

  // reference model state
  int          m_flush_left = 0;
  int          m_waited     = 0;
  bit          m_waiting    = 1'b0;
  int unsigned m_pst = 0, m_pfl = 0, m_pwt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // exp bits: {flush_fetch, flush_decode, stall_fetch, freeze, mem_timeout}
  task automatic chk_ctl(input string name, input logic [4:0] exp);
    @(negedge clk);
    chk(name, {27'd0, flush_fetch, flush_decode, stall_fetch, freeze, mem_timeout}, {27'd0, exp});
    next_cycle();
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    ex_regwrite = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs)    return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            name           id1 id2 ex1 ex2 exrd rw ld memrd mw wbrd ww  st fd fa     fb
    tbl[0]  = '{"lu_stall",      5,  2,  0,  0,  5,   1, 1, 0,    0, 0,   0,  1, 1, 2'b00, 2'b00};
    tbl[1]  = '{"lu_bubble",     5,  2,  0,  0,  0,   0, 0, 5,    1, 0,   0,  0, 0, 2'b00, 2'b00};
    tbl[2]  = '{"lu_fwd_wb",     0,  0,  5,  2,  6,   1, 0, 0,    0, 5,   1,  0, 0, 2'b01, 2'b00};
    tbl[3]  = '{"fwd_mem_pri",   0,  0,  1,  3,  0,   0, 0, 3,    1, 3,   1,  0, 0, 2'b00, 2'b10};
    tbl[4]  = '{"fwd_wb_only",   0,  0,  1,  3,  0,   0, 0, 4,    1, 3,   1,  0, 0, 2'b00, 2'b01};
    tbl[5]  = '{"fwd_x0",        0,  0,  0,  0,  0,   0, 0, 0,    1, 0,   1,  0, 0, 2'b00, 2'b00};
    tbl[6]  = '{"lu_x0",         0,  0,  0,  0,  0,   1, 1, 0,    0, 0,   0,  0, 0, 2'b00, 2'b00};
    tbl[7]  = '{"lu_rs2",        1,  7,  0,  0,  7,   1, 1, 0,    0, 0,   0,  1, 1, 2'b00, 2'b00};
    tbl[8]  = '{"lu_not_load",   7,  0,  0,  0,  7,   1, 0, 0,    0, 0,   0,  0, 0, 2'b00, 2'b00};
    tbl[9]  = '{"lu_no_rw",      7,  0,  0,  0,  7,   0, 1, 0,    0, 0,   0,  0, 0, 2'b00, 2'b00};
    tbl[10] = '{"fwd_mem_nowe",  0,  0,  3,  0,  0,   0, 0, 3,    0, 3,   1,  0, 0, 2'b01, 2'b00};
    tbl[11] = '{"fwd_both_ops",  0,  0,  4,  9,  0,   0, 0, 4,    1, 9,   1,  0, 0, 2'b10, 2'b01};

    // reset: forwarding inputs would match, yet outputs must be forced
    idle_inputs();
    rst = 1'b1;
    mem_rd = 5'd3; mem_regwrite = 1'b1; wb_rd = 5'd3; wb_regwrite = 1'b1;
    ex_rs1 = 5'd3; ex_rs2 = 5'd3;
    @(negedge clk);
    chk("rst_ctl", {27'd0, flush_fetch, flush_decode, stall_fetch, freeze, mem_timeout}, 32'b11000);
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_perf", perf_stall_cycles | perf_flush_events | perf_wait_cycles, 32'd0);
`endif
    next_cycle();
    chk_ctl("rst_ctl2", 5'b11000);
    rst = 1'b0;
    idle_inputs();
    chk_ctl("run_idle", 5'b00000);

    for (int i = 0; i < 12; i++) begin
      id_rs1 = tbl[i].id_rs1; id_rs2 = tbl[i].id_rs2;
      ex_rs1 = tbl[i].ex_rs1; ex_rs2 = tbl[i].ex_rs2; ex_rd = tbl[i].ex_rd;
      ex_regwrite = tbl[i].ex_regwrite; ex_is_load = tbl[i].ex_is_load;
      mem_rd = tbl[i].mem_rd; mem_regwrite = tbl[i].mem_regwrite;
      wb_rd = tbl[i].wb_rd; wb_regwrite = tbl[i].wb_regwrite;
      @(negedge clk);
      chk(tbl[i].name,
          {26'd0, flush_fetch, freeze, stall_fetch, flush_decode, fwd_a, fwd_b},
          {26'd0, 1'b0, 1'b0, tbl[i].exp_stall, tbl[i].exp_fd, tbl[i].exp_fa, tbl[i].exp_fb});
      next_cycle();
    end
    idle_inputs();

    // redirect with FLUSH_CYCLES=2
    ex_redirect = 1'b1;
    chk_ctl("redir_c1", 5'b11000);
    ex_redirect = 1'b0;
    chk_ctl("redir_c2", 5'b10000);
    chk_ctl("redir_done", 5'b00000);

    // redirect overrides load-use
    ex_redirect = 1'b1; ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    chk_ctl("redir_over_lu", 5'b11000);
    idle_inputs();
    chk_ctl("redir_over_lu2", 5'b10000);

    // memory wait with a pending redirect: no flush until after ready
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk_ctl($sformatf("wait_c%0d", i),
              (i == 1) ? 5'b00010 : ((i == 3) ? 5'b00111 : 5'b00110));
    end
    dmem_ready = 1'b1;
    chk_ctl("wait_exit", 5'b00000);
    dmem_req = 1'b0; dmem_ready = 1'b0;
    chk_ctl("wait_redir1", 5'b11000);
    ex_redirect = 1'b0;
    chk_ctl("wait_redir2", 5'b10000);

    // timeout: ready low for 10 cycles
    begin
      int pulses, pulse_at, frz;
      pulses = 0; pulse_at = 0; frz = 0;
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (freeze) frz++;
        if (mem_timeout) begin pulses++; pulse_at = i; end
        next_cycle();
      end
      chk("tmo_pulses", pulses, 1);
      chk("tmo_position", pulse_at, 3);
      chk("tmo_freeze", frz, 10);
      dmem_ready = 1'b1;
      chk_ctl("tmo_exit", 5'b00000);
      idle_inputs();
    end

    // reset mid-wait
    dmem_req = 1'b1; dmem_ready = 1'b0;
    chk_ctl("rw_enter", 5'b00010);
    chk_ctl("rw_wait", 5'b00110);
    rst = 1'b1;
    chk_ctl("rw_rst", 5'b11000);
    rst = 1'b0; dmem_req = 1'b0;
    @(negedge clk);
    chk("rw_after", {27'd0, flush_fetch, flush_decode, stall_fetch, freeze, mem_timeout}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rw_perf_stall", perf_stall_cycles, 32'd0);
    chk("rw_perf_flush", perf_flush_events, 32'd0);
    chk("rw_perf_wait", perf_wait_cycles, 32'd0);
`endif
    next_cycle();

    // reset mid-redirect
    ex_redirect = 1'b1;
    chk_ctl("rr_redir", 5'b11000);
    ex_redirect = 1'b0; rst = 1'b1;
    chk_ctl("rr_rst", 5'b11000);
    rst = 1'b0;
    chk_ctl("rr_after", 5'b00000);

    // randomized run against the reference model
    for (int c = 0; c < 600; c++) begin
      logic       e_ff, e_fd, e_st, e_frz, e_tmo;
      logic [1:0] e_fa, e_fb;
      rst          = (c == 0) || ($urandom_range(0, 39) == 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rs1       = 5'($urandom_range(0, 3));
      ex_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      wb_rd        = 5'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_is_load   = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1));
      wb_regwrite  = 1'($urandom_range(0, 1));
      ex_redirect  = ($urandom_range(0, 6) == 0);
      dmem_req     = ($urandom_range(0, 2) == 0);
      dmem_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);

`ifdef HAZARD_PERF_CNT_EN
      chk("rand_perf_stall", perf_stall_cycles, m_pst);
      chk("rand_perf_flush", perf_flush_events, m_pfl);
      chk("rand_perf_wait", perf_wait_cycles, m_pwt);
`endif
      e_ff = 0; e_fd = 0; e_st = 0; e_frz = 0; e_tmo = 0;
      e_fa = rst ? 2'b00 : ref_fwd(ex_rs1);
      e_fb = rst ? 2'b00 : ref_fwd(ex_rs2);
      if (rst) begin
        e_ff = 1; e_fd = 1;
        m_flush_left = 0; m_waiting = 0; m_waited = 0;
        m_pst = 0; m_pfl = 0; m_pwt = 0;
      end else if (m_waiting) begin
        m_pwt++;
        if (dmem_ready) begin
          m_waiting = 0; m_waited = 0;
        end else begin
          m_waited++;
          e_frz = 1; e_st = 1;
          e_tmo = (MT != 0) && (m_waited == int'(MT));
        end
      end else if (m_flush_left > 0) begin
        e_ff = 1;
        if (ex_redirect) begin m_flush_left = FC - 1; m_pfl++; end
        else m_flush_left--;
      end else if (dmem_req && !dmem_ready) begin
        m_waiting = 1; m_waited = 1;
        e_frz = 1;
        e_tmo = (MT == 1);
      end else if (ex_redirect) begin
        e_ff = 1; e_fd = 1;
        m_flush_left = FC - 1; m_pfl++;
      end else if (ex_is_load && ex_regwrite && ex_rd != 0 &&
                   (ex_rd == id_rs1 || ex_rd == id_rs2)) begin
        e_st = 1; e_fd = 1; m_pst++;
      end
      chk("rand_ctl", {27'd0, flush_fetch, flush_decode, stall_fetch, freeze, mem_timeout},
          {27'd0, e_ff, e_fd, e_st, e_frz, e_tmo});
      chk("rand_fwd", {28'd0, fwd_a, fwd_b}, {28'd0, e_fa, e_fb});
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
